disp7seg_scan: RTL and testbench

DISP7SEG_SCAN -- requirements
Module: disp7seg_scan

---
 rtl/disp7seg_scan.sv | 135 +++++++++++++
 tb/tb_disp7seg_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp7seg_scan.sv
// Four-digit multiplexed seven-segment scanner with inter-digit blanking,
// per-frame input snapshot and leading-zero suppression.
module disp7seg_scan #(
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clocken,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lzb,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(BLANK_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [7:0]  cnt;
    logic [15:0] sh_data;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_blank;
    logic        sh_lzb;

    logic [3:0]  lz;
    logic [3:0]  nib;
    logic        dark;
    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'b1000000;
            4'h1: hex2seg = 7'b1111001;
            4'h2: hex2seg = 7'b0100100;
            4'h3: hex2seg = 7'b0110000;
            4'h4: hex2seg = 7'b0011001;
            4'h5: hex2seg = 7'b0010010;
            4'h6: hex2seg = 7'b0000010;
            4'h7: hex2seg = 7'b1111000;
            4'h8: hex2seg = 7'b0000000;
            4'h9: hex2seg = 7'b0010000;
            4'hA: hex2seg = 7'b0001000;
            4'hB: hex2seg = 7'b0000011;
            4'hC: hex2seg = 7'b1000110;
            4'hD: hex2seg = 7'b0100001;
            4'hE: hex2seg = 7'b0000110;
            default: hex2seg = 7'b0001110;
        endcase
    endfunction

    // State register: index, blank counter and FSM state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= BLANK;
            idx   <= 2'd3;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (clocken) begin
                idx <= idx + 2'd1;
                cnt <= CNT_LOAD;
            end else if (state == BLANK && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (clocken)
            state_nxt = BLANK;
        else if (state == BLANK && cnt == 8'd0)
            state_nxt = DRIVE;
    end

    // Snapshot on the wrap edge so a whole frame shows one consistent value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_data    <= 16'h0;
            sh_dp      <= 4'h0;
            sh_blank   <= 4'h0;
            sh_lzb     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= clocken && (idx == 2'd3);
            if (clocken && idx == 2'd3) begin
                sh_data  <= data;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
                sh_lzb   <= lzb;
            end
        end
    end

    // lz[i]: digits i..3 are all zero with no decimal point lit
    assign lz[3] = (sh_data[15:12] == 4'h0) && !sh_dp[3];
    for (genvar i = 0; i < 3; i++) begin : g_lz
        assign lz[i] = lz[i+1] && (sh_data[i*4 +: 4] == 4'h0) && !sh_dp[i];
    end

    assign nib  = sh_data[{idx, 2'b00} +: 4];
    assign dark = sh_blank[idx] || (sh_lzb && idx != 2'd0 && lz[idx]);

    always_comb begin
        an_nxt  = 4'hF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (state_nxt == DRIVE && !dark) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = hex2seg(nib);
            dp_nxt  = ~sh_dp[idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_disp7seg_scan.sv
// Bench for disp7seg_scan: directed frames plus random traffic, all outputs
// compared every cycle against an edge-count based reference model.
module tb_disp7seg_scan;

    localparam int BC = 16;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clocken = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic        lzb = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    disp7seg_scan #(.BLANK_CYCLES(BC)) dut (
        .clock(clock), .reset(reset), .clocken(clocken), .data(data),
        .dp_in(dp_in), .blank_in(blank_in), .lzb(lzb), .seg(seg), .dp(dp),
        .an(an), .frame_done(frame_done));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a digit lights once BC edges have passed since its clocken
    int          m_idx;
    int          m_since;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blank;
    logic        m_lzb, m_fd;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_idx <= 3; m_since <= BC - 1; m_data <= 16'h0; m_dp <= 4'h0;
            m_blank <= 4'h0; m_lzb <= 1'b0; m_fd <= 1'b0;
        end else if (clocken) begin
            m_idx   <= (m_idx + 1) % 4;
            m_since <= 0;
            m_fd    <= (m_idx == 3);
            if (m_idx == 3) begin
                m_data <= data; m_dp <= dp_in; m_blank <= blank_in; m_lzb <= lzb;
            end
        end else begin
            if (m_since < 1000) m_since <= m_since + 1;
            m_fd <= 1'b0;
        end
    end

    function automatic logic [11:0] exp_out();
        logic on;
        logic allz;
        logic [3:0] nib;
        nib = m_data[m_idx*4 +: 4];
        on = (m_since >= BC) && !m_blank[m_idx];
        if (m_lzb && m_idx > 0) begin
            allz = 1'b1;
            for (int d = m_idx; d < 4; d++)
                if (m_data[d*4 +: 4] != 4'h0 || m_dp[d]) allz = 1'b0;
            if (allz) on = 1'b0;
        end
        if (on) return {~(4'b0001 << m_idx), SEG[nib], ~m_dp[m_idx]};
        return 12'hFFF;
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            logic [11:0] e;
            e = exp_out();
            chk("mon.an", 32'(an), 32'(e[11:8]));
            chk("mon.seg", 32'(seg), 32'(e[7:1]));
            chk("mon.dp", 32'(dp), 32'(e[0]));
            chk("mon.fd", 32'(frame_done), 32'(m_fd));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called right after a negedge; returns at the negedge after the clocken edge
    task automatic ck();
        clocken = 1'b1;
        @(negedge clock);
        clocken = 1'b0;
    endtask

    task automatic show(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        ck();
        step(BC - 1);
        chk({tag, ".pre"}, 32'(an), 32'hF);
        step(1);
        chk({tag, ".an"}, 32'(an), 32'(ea));
        chk({tag, ".seg"}, 32'(seg), 32'(es));
        chk({tag, ".dp"}, 32'(dp), 32'(ed));
        step(49 - BC);
    endtask

    initial begin
        step(3);
        chk("rst.an", 32'(an), 32'hF);
        chk("rst.seg", 32'(seg), 32'h7F);
        chk("rst.dp", 32'(dp), 32'h1);
        chk("rst.fd", 32'(frame_done), 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        step(5);

        // 1234 frame, new data arrives while digit 2 is on
        data = 16'h1234;
        ck();
        chk("f1.fd", 32'(frame_done), 32'h1);
        step(BC - 1);
        chk("f1.d0.pre", 32'(an), 32'hF);
        step(1);
        chk("f1.d0.an", 32'(an), 32'hE);
        chk("f1.d0.seg", 32'(seg), 32'(7'b0011001));
        step(49 - BC);
        show("f1.d1", 4'b1101, 7'b0110000, 1'b1);
        ck();
        step(BC);
        data = 16'hABCD;
        step(2);
        chk("f1.d2.an", 32'(an), 32'(4'b1011));
        chk("f1.d2.seg", 32'(seg), 32'(7'b0100100));
        step(47 - BC);
        show("f1.d3", 4'b0111, 7'b1111001, 1'b1);
        show("f2.d0", 4'b1110, 7'b0100001, 1'b1);
        show("f2.d1", 4'b1101, 7'b1000110, 1'b1);
        show("f2.d2", 4'b1011, 7'b0000011, 1'b1);
        show("f2.d3", 4'b0111, 7'b0001000, 1'b1);

        // Leading-zero blanking, then a lit dp stops it at digit 2
        data = 16'h0050; lzb = 1'b1;
        show("f3.d0", 4'b1110, 7'b1000000, 1'b1);
        show("f3.d1", 4'b1101, 7'b0010010, 1'b1);
        show("f3.d2", 4'b1111, 7'b1111111, 1'b1);
        show("f3.d3", 4'b1111, 7'b1111111, 1'b1);
        dp_in = 4'b0100;
        show("f4.d0", 4'b1110, 7'b1000000, 1'b1);
        show("f4.d1", 4'b1101, 7'b0010010, 1'b1);
        show("f4.d2", 4'b1011, 7'b1000000, 1'b0);
        show("f4.d3", 4'b1111, 7'b1111111, 1'b1);

        // Forced blank on digit 0
        data = 16'h8888; dp_in = 4'h0; lzb = 1'b0; blank_in = 4'b0001;
        show("f5.d0", 4'b1111, 7'b1111111, 1'b1);
        show("f5.d1", 4'b1101, 7'b0000000, 1'b1);
        show("f5.d2", 4'b1011, 7'b0000000, 1'b1);
        show("f5.d3", 4'b0111, 7'b0000000, 1'b1);

        // clocken faster than the blanking time: never lit, index still steps
        for (int k = 0; k < 8; k++) begin
            ck();
            chk("fast.fd", 32'(frame_done), 32'(k % 4 == 0));
            repeat (4) begin
                chk("fast.an", 32'(an), 32'hF);
                @(negedge clock);
            end
        end
        ck();
        chk("fast.wrap", 32'(frame_done), 32'h1);
        step(20);

        // Asynchronous reset three cycles into DRIVE
        blank_in = 4'h0;
        step(30);
        ck();
        step(BC + 3);
        chk("ar.lit", 32'(an), 32'(4'b1101));
        #2 reset = 1'b1;
        #1;
        chk("ar.an", 32'(an), 32'hF);
        chk("ar.seg", 32'(seg), 32'h7F);
        @(negedge clock);
        step(2);
        reset = 1'b0;
        step(3);
        ck();
        chk("ar.fd", 32'(frame_done), 32'h1);
        step(BC);
        chk("ar.an0", 32'(an), 32'hE);
        chk("ar.seg0", 32'(seg), 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            clocken = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) begin
                logic [15:0] m;
                m = {{4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}},
                     {4{1'($urandom_range(0, 1))}}, 4'hF};
                data     = 16'($urandom) & m;
                dp_in    = 4'($urandom) & 4'($urandom) & 4'($urandom);
                blank_in = 4'($urandom) & 4'($urandom);
                lzb      = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clock);
        clocken = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
